hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, 32: registers per file; power of two.
REQ-002 Parameter LAT_W, 4: latency field width; max latency is 2^LAT_W-1.
REQ-003 Parameter NFILE, 2: register files; file 0 integer, file 1 FPU.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rstn  in  1  synchronous, active-high reset (1 = reset); polarity and synchronicity fixed.
REQ-006 id_valid  in  1  instruction in ID requests issue.
REQ-007 rs1_id, rs2_id  in  log2(NREG) each  source register indices.
REQ-008 rs1_fpu_id, rs2_fpu_id, rd_fpu_id  in  1 each  file select per operand, 1 = FPU.
REQ-009 rd_id  in  log2(NREG)  destination index.
REQ-010 regwrite_id  in  1  instruction writes rd.
REQ-011 lat_id  in  LAT_W  cycles after issue until the result is forwardable.
REQ-012 id_flush  in  1  kills the ID instruction this cycle (branch taken).
REQ-013 hold  in  1  global freeze (memory or multi-cycle ALU not ready).
REQ-014 wb_valid, rd_wb, rd_fpu_wb  in  1/log2(NREG)/1  writeback retires a destination.
REQ-015 stall_id  out  1  combinational; ID must not advance.
REQ-016 issue_fire  out  1  combinational; id_valid & !stall_id & !id_flush & !hold.
REQ-017 pending_any  out  1  registered; any entry pending.

Function
REQ-018 Each entry (file f, register r) holds cnt[LAT_W] and pend[1].
REQ-019 Integer register 0 is never tracked: its cnt and pend stay 0, and sources naming it never stall. FPU register 0 is tracked.
REQ-020 RAW: stall_id = 1 when id_valid & !id_flush and either source entry has cnt != 0.
REQ-021 WAW: stall_id = 1 when regwrite_id & pend[rd] & cnt[rd] > lat_id.
REQ-022 On issue_fire & regwrite_id: cnt[rd] <= lat_id; pend[rd] <= 1.
REQ-023 When hold = 0, every other nonzero cnt decrements by 1 per cycle, saturating at 0.
REQ-024 When hold = 1, cnt and pend are frozen; stall_id is still evaluated and issue_fire = 0.
REQ-025 When wb_valid = 1, pend[rd_wb] is cleared.
REQ-026 Simultaneous issue to and writeback from the same entry: issue wins (pend = 1, cnt = lat_id).
REQ-027 lat_id = 0 yields cnt = 0, so a dependent instruction in the next cycle does not stall.
REQ-028 id_flush = 1 suppresses both stall_id and issue for that cycle.
REQ-029 pending_any is the registered OR of all pend bits and lags by one cycle.

Reset
REQ-030 When rstn = 1 at a clock edge: all cnt = 0, all pend = 0, pending_any = 0, and statistics counters = 0.
REQ-031 Reset during pending operations discards them; from the next cycle stall_id = 0 for any operands.

Configuration
REQ-032 HAZARD_SCOREBOARD_STATS_EN defined adds output stall_cycles [31:0], which counts cycles with stall_id & !hold and saturates at 0xFFFFFFFF.
REQ-033 HAZARD_SCOREBOARD_STATS_EN undefined: no stall_cycles port and no counter logic; all other behaviour is identical.

Structure
REQ-034 Package core_pkg holds the NREG, LAT_W and NFILE defaults and constants FILE_INT = 0 and FILE_FPU = 1.
REQ-035 Sub-module scoreboard_entry implements one entry: cnt/pend registers, load, decrement, hold, clear. The top instantiates NFILE*NREG entries and does the read muxes and stall logic.

Verification
REQ-036 Issue x5, lat 3, then x5 as source each cycle -> stall_id = 1 for 3 cycles, 0 on the 4th.
REQ-037 Issue f2, lat 2; next cycle source x2 (integer) -> no stall; source f2 -> stall 2 cycles.
REQ-038 Issue x7, lat 4, hold = 1 for 2 cycles, then hold = 0 -> x7 dependents stall 6 cycles total.
REQ-039 Issue x0, lat 5, then source x0 -> stall_id = 0 and pending_any stays 0.
REQ-040 x9 pending with cnt 5; new write to x9 with lat 2 -> stall (WAW); with lat 6 -> no stall and cnt = 6.
REQ-041 x3 pending, rstn = 1 for one cycle -> next cycle source x3 gives stall_id = 0, pending_any = 0, and stall_cycles = 0 when HAZARD_SCOREBOARD_STATS_EN is defined.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// core_pkg : shared defaults and register-file identifiers.   Rev 1.0
// ----------------------------------------------------------------------------
package core_pkg;
  localparam int DEF_NREG  = 32;
  localparam int DEF_LAT_W = 4;
  localparam int DEF_NFILE = 2;
  localparam int FILE_INT  = 0;
  localparam int FILE_FPU  = 1;
endpackage
`default_nettype wire

// File: rtl/scoreboard_entry.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scoreboard_entry : one latency counter plus pending bit.   Rev 1.0
// ----------------------------------------------------------------------------
module scoreboard_entry
  import core_pkg::*;
#(
  parameter int LAT_W   = DEF_LAT_W,
  parameter bit TRACKED = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_hold,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_lat,
  input  logic             i_clear,
  output logic [LAT_W-1:0] o_cnt,
  output logic             o_pend
);

  logic [LAT_W-1:0] r_cnt;
  logic             r_pend;

  // A new issue takes priority over a same-cycle writeback to this entry.
  always_ff @(posedge clk) begin
    if (rstn || !TRACKED) begin
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else if (!i_hold) begin
      if (i_load) begin
        r_cnt  <= i_lat;
        r_pend <= 1'b1;
      end else begin
        if (r_cnt != '0) r_cnt <= r_cnt - LAT_W'(1);
        if (i_clear) r_pend <= 1'b0;
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_pend = r_pend;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_scoreboard : RAW/WAW issue scoreboard for integer and FPU files.
// Define HAZARD_SCOREBOARD_STATS_EN to add the stall_cycles counter.  Rev 1.0
// ----------------------------------------------------------------------------
module hazard_scoreboard
  import core_pkg::*;
#(
  parameter int NREG  = DEF_NREG,
  parameter int LAT_W = DEF_LAT_W,
  parameter int NFILE = DEF_NFILE,
  localparam int RW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic [RW-1:0]    rs1_id,
  input  logic [RW-1:0]    rs2_id,
  input  logic             rs1_fpu_id,
  input  logic             rs2_fpu_id,
  input  logic             rd_fpu_id,
  input  logic [RW-1:0]    rd_id,
  input  logic             regwrite_id,
  input  logic [LAT_W-1:0] lat_id,
  input  logic             id_flush,
  input  logic             hold,
  input  logic             wb_valid,
  input  logic [RW-1:0]    rd_wb,
  input  logic             rd_fpu_wb,
  output logic             stall_id,
  output logic             issue_fire,
  output logic             pending_any
`ifdef HAZARD_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  localparam int NENT  = NFILE * NREG;
  localparam int IDX_W = RW + 1;

  logic [LAT_W-1:0] w_cnt [NENT];
  logic [NENT-1:0]  w_pend;
  logic [IDX_W-1:0] w_rs1_idx, w_rs2_idx, w_rd_idx, w_wb_idx;
  logic             w_load, w_raw, w_waw;
  logic             r_pending_any;

  // Entry index is {file select, register}; integer x0 is hard-wired untracked.
  assign w_rs1_idx = {rs1_fpu_id, rs1_id};
  assign w_rs2_idx = {rs2_fpu_id, rs2_id};
  assign w_rd_idx  = {rd_fpu_id, rd_id};
  assign w_wb_idx  = {rd_fpu_wb, rd_wb};
  assign w_load    = issue_fire && regwrite_id;

  for (genvar e = 0; e < NENT; e++) begin : g_entry
    scoreboard_entry #(
      .LAT_W   (LAT_W),
      .TRACKED (e != FILE_INT * NREG)
    ) u_entry (
      .clk     (clk),
      .rstn    (rstn),
      .i_hold  (hold),
      .i_load  (w_load && (w_rd_idx == IDX_W'(e))),
      .i_lat   (lat_id),
      .i_clear (wb_valid && (w_wb_idx == IDX_W'(e))),
      .o_cnt   (w_cnt[e]),
      .o_pend  (w_pend[e])
    );
  end

  assign w_raw      = (w_cnt[w_rs1_idx] != '0) || (w_cnt[w_rs2_idx] != '0);
  assign w_waw      = w_pend[w_rd_idx] && (w_cnt[w_rd_idx] > lat_id);
  assign stall_id   = !id_flush && ((id_valid && w_raw) || (regwrite_id && w_waw));
  assign issue_fire = id_valid && !stall_id && !id_flush && !hold;

  always_ff @(posedge clk) begin
    if (rstn) r_pending_any <= 1'b0;
    else      r_pending_any <= |w_pend;
  end
  assign pending_any = r_pending_any;

`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] r_stall_cycles;
  always_ff @(posedge clk) begin
    if (rstn)
      r_stall_cycles <= '0;
    else if (stall_id && !hold && (r_stall_cycles != 32'hFFFF_FFFF))
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end
  assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hazard_scoreboard : directed self-checking bench for hazard_scoreboard.
// ----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rstn;
  logic       id_valid, rs1_fpu_id, rs2_fpu_id, rd_fpu_id, regwrite_id;
  logic [4:0] rs1_id, rs2_id, rd_id, rd_wb;
  logic [3:0] lat_id;
  logic       id_flush, hold, wb_valid, rd_fpu_wb;
  logic       stall_id, issue_fire, pending_any;
`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk         (clk),
    .rstn        (rstn),
    .id_valid    (id_valid),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .rs1_fpu_id  (rs1_fpu_id),
    .rs2_fpu_id  (rs2_fpu_id),
    .rd_fpu_id   (rd_fpu_id),
    .rd_id       (rd_id),
    .regwrite_id (regwrite_id),
    .lat_id      (lat_id),
    .id_flush    (id_flush),
    .hold        (hold),
    .wb_valid    (wb_valid),
    .rd_wb       (rd_wb),
    .rd_fpu_wb   (rd_fpu_wb),
    .stall_id    (stall_id),
    .issue_fire  (issue_fire),
    .pending_any (pending_any)
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  task automatic idle();
    id_valid = 0; rs1_id = 0; rs2_id = 0; rs1_fpu_id = 0; rs2_fpu_id = 0;
    rd_id = 0; rd_fpu_id = 0; regwrite_id = 0; lat_id = 0;
    id_flush = 0; hold = 0; wb_valid = 0; rd_wb = 0; rd_fpu_wb = 0;
  endtask

  task automatic drive_id(input logic [4:0] r1, input logic f1, input logic [4:0] r2,
                          input logic f2, input logic [4:0] rd, input logic fd,
                          input logic rw, input logic [3:0] lat);
    id_valid = 1; rs1_id = r1; rs1_fpu_id = f1; rs2_id = r2; rs2_fpu_id = f2;
    rd_id = rd; rd_fpu_id = fd; regwrite_id = rw; lat_id = lat;
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); rstn = 1;
    @(negedge clk); rstn = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); idle(); drive_id(5'd5, 0, 5'd17, 1, 5'd0, 0, 0, 4'd0); #1;
    n_tests++;
    if (stall_id !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_id); end
    n_tests++;
    if (pending_any !== 1'b0) begin n_fail++; $display("FAIL reset_pending_any: got %b want 0", pending_any); end
    n_tests++;
    if (issue_fire !== 1'b1) begin n_fail++; $display("FAIL reset_issue_fire: got %b want 1", issue_fire); end
`ifdef HAZARD_SCOREBOARD_STATS_EN
    n_tests++;
    if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles); end
`endif
  endtask

  task automatic test_raw_int();
    do_reset();
    @(negedge clk); drive_id(5'd0, 0, 5'd0, 0, 5'd5, 0, 1, 4'd3); #1;
    n_tests++;
    if (issue_fire !== 1'b1) begin n_fail++; $display("FAIL raw_issue: got %b want 1", issue_fire); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); idle(); drive_id(5'd5, 0, 5'd0, 0, 5'd0, 0, 0, 4'd0); #1;
      n_tests++;
      if (stall_id !== (c < 3)) begin n_fail++; $display("FAIL raw_x5_c%0d: stall got %b want %b", c, stall_id, (c < 3)); end
      if (c == 0) begin
        n_tests++;
        if (pending_any !== 1'b0) begin n_fail++; $display("FAIL raw_pend_lag: got %b want 0", pending_any); end
      end
      if (c == 1) begin
        n_tests++;
        if (pending_any !== 1'b1) begin n_fail++; $display("FAIL raw_pend_set: got %b want 1", pending_any); end
      end
`ifdef HAZARD_SCOREBOARD_STATS_EN
      if (c == 3) begin
        n_tests++;
        if (stall_cycles !== 32'd3) begin n_fail++; $display("FAIL raw_stall_cycles: got %0d want 3", stall_cycles); end
      end
`endif
    end
  endtask

  task automatic test_fpu();
    do_reset();
    @(negedge clk); drive_id(5'd0, 0, 5'd0, 0, 5'd2, 1, 1, 4'd2);
    @(negedge clk); idle(); drive_id(5'd2, 0, 5'd0, 0, 5'd0, 0, 0, 4'd0); #1;
    n_tests++;
    if (stall_id !== 1'b0) begin n_fail++; $display("FAIL fpu_int_x2: stall got %b want 0", stall_id); end
    rs1_fpu_id = 1; #1;
    n_tests++;
    if (stall_id !== 1'b1) begin n_fail++; $display("FAIL fpu_f2_c0: stall got %b want 1", stall_id); end
    @(negedge clk); drive_id(5'd0, 0, 5'd2, 1, 5'd0, 0, 0, 4'd0); #1;
    n_tests++;
    if (stall_id !== 1'b1) begin n_fail++; $display("FAIL fpu_f2_c1: stall got %b want 1", stall_id); end
    @(negedge clk); #1;
    n_tests++;
    if (stall_id !== 1'b0) begin n_fail++; $display("FAIL fpu_f2_c2: stall got %b want 0", stall_id); end
  endtask

  task automatic test_hold();
    int stalls = 0;
    bit done = 0;
    do_reset();
    @(negedge clk); drive_id(5'd0, 0, 5'd0, 0, 5'd7, 0, 1, 4'd4);
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk); idle(); hold = (c < 2); drive_id(5'd0, 0, 5'd7, 0, 5'd0, 0, 0, 4'd0); #1;
      if (c == 0) begin
        n_tests++;
        if (issue_fire !== 1'b0) begin n_fail++; $display("FAIL hold_issue_fire: got %b want 0", issue_fire); end
      end
      if (stall_id) stalls++; else done = 1;
    end
    hold = 0;
    n_tests++;
    if (stalls != 6) begin n_fail++; $display("FAIL hold_stall_count: got %0d want 6", stalls); end
`ifdef HAZARD_SCOREBOARD_STATS_EN
    n_tests++;
    if (stall_cycles !== 32'd4) begin n_fail++; $display("FAIL hold_stall_cycles: got %0d want 4", stall_cycles); end
`endif
  endtask

  task automatic test_x0();
    do_reset();
    @(negedge clk); drive_id(5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 4'd5); #1;
    n_tests++;
    if (issue_fire !== 1'b1) begin n_fail++; $display("FAIL x0_issue: got %b want 1", issue_fire); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle(); drive_id(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 4'd0); #1;
      n_tests++;
      if (stall_id !== 1'b0 || pending_any !== 1'b0) begin
        n_fail++; $display("FAIL x0_c%0d: stall=%b pend_any=%b want 0/0", c, stall_id, pending_any);
      end
    end
  endtask

  task automatic test_waw();
    int stalls = 0;
    bit done = 0;
    do_reset();
    @(negedge clk); drive_id(5'd0, 0, 5'd0, 0, 5'd9, 0, 1, 4'd5);
    @(negedge clk); drive_id(5'd0, 0, 5'd0, 0, 5'd9, 0, 1, 4'd2); #1;
    n_tests++;
    if (stall_id !== 1'b1 || issue_fire !== 1'b0) begin
      n_fail++; $display("FAIL waw_lat2: stall=%b fire=%b want 1/0", stall_id, issue_fire);
    end
    lat_id = 4'd5; #1;
    n_tests++;
    if (stall_id !== 1'b0) begin n_fail++; $display("FAIL waw_lat_equal: stall got %b want 0", stall_id); end
    lat_id = 4'd6; #1;
    n_tests++;
    if (stall_id !== 1'b0 || issue_fire !== 1'b1) begin
      n_fail++; $display("FAIL waw_lat6: stall=%b fire=%b want 0/1", stall_id, issue_fire);
    end
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk); idle(); drive_id(5'd9, 0, 5'd0, 0, 5'd0, 0, 0, 4'd0); #1;
      if (stall_id) stalls++; else done = 1;
    end
    n_tests++;
    if (stalls != 6) begin n_fail++; $display("FAIL waw_new_cnt: stall cycles got %0d want 6", stalls); end
  endtask

  task automatic test_lat0_wb();
    do_reset();
    @(negedge clk); drive_id(5'd0, 0, 5'd0, 0, 5'd4, 0, 1, 4'd0);
    @(negedge clk); idle(); drive_id(5'd4, 0, 5'd4, 0, 5'd0, 0, 0, 4'd0); #1;
    n_tests++;
    if (stall_id !== 1'b0) begin n_fail++; $display("FAIL lat0_dep: stall got %b want 0", stall_id); end
    @(negedge clk); idle(); wb_valid = 1; rd_wb = 5'd4; #1;
    n_tests++;
    if (pending_any !== 1'b1) begin n_fail++; $display("FAIL lat0_pend: got %b want 1", pending_any); end
    @(negedge clk); idle(); #1;
    n_tests++;
    if (pending_any !== 1'b1) begin n_fail++; $display("FAIL wb_lag: got %b want 1", pending_any); end
    @(negedge clk); #1;
    n_tests++;
    if (pending_any !== 1'b0) begin n_fail++; $display("FAIL wb_clear: got %b want 0", pending_any); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    // Issue x6 and retire x6 in the same cycle: the issue must win.
    @(negedge clk); drive_id(5'd0, 0, 5'd0, 0, 5'd6, 0, 1, 4'd3); wb_valid = 1; rd_wb = 5'd6;
    @(negedge clk); idle(); drive_id(5'd6, 0, 5'd0, 0, 5'd0, 0, 0, 4'd0); #1;
    n_tests++;
    if (stall_id !== 1'b1) begin n_fail++; $display("FAIL b2b_stall: got %b want 1", stall_id); end
    @(negedge clk); idle(); #1;
    n_tests++;
    if (pending_any !== 1'b1) begin n_fail++; $display("FAIL b2b_pend: got %b want 1", pending_any); end
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk); drive_id(5'd0, 0, 5'd0, 0, 5'd5, 0, 1, 4'd3);
    @(negedge clk); drive_id(5'd5, 0, 5'd0, 0, 5'd8, 0, 1, 4'd4); id_flush = 1; #1;
    n_tests++;
    if (stall_id !== 1'b0 || issue_fire !== 1'b0) begin
      n_fail++; $display("FAIL flush: stall=%b fire=%b want 0/0", stall_id, issue_fire);
    end
    @(negedge clk); idle(); drive_id(5'd8, 0, 5'd0, 0, 5'd0, 0, 0, 4'd0); #1;
    n_tests++;
    if (stall_id !== 1'b0) begin n_fail++; $display("FAIL flush_no_load: stall got %b want 0", stall_id); end
  endtask

  task automatic test_reset_pending();
    do_reset();
    @(negedge clk); drive_id(5'd0, 0, 5'd0, 0, 5'd3, 0, 1, 4'd5);
    @(negedge clk); idle(); drive_id(5'd3, 0, 5'd0, 0, 5'd0, 0, 0, 4'd0); #1;
    n_tests++;
    if (stall_id !== 1'b1) begin n_fail++; $display("FAIL rstp_before: stall got %b want 1", stall_id); end
    @(negedge clk); rstn = 1;
    @(negedge clk); rstn = 0; #1;
    n_tests++;
    if (stall_id !== 1'b0 || pending_any !== 1'b0) begin
      n_fail++; $display("FAIL rstp_after: stall=%b pend_any=%b want 0/0", stall_id, pending_any);
    end
`ifdef HAZARD_SCOREBOARD_STATS_EN
    n_tests++;
    if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL rstp_stall_cycles: got %0d want 0", stall_cycles); end
`endif
  endtask

  initial begin
    idle();
    rstn = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 0;
    test_reset();
    test_raw_int();
    test_fpu();
    test_hold();
    test_x0();
    test_waw();
    test_lat0_wb();
    test_back_to_back();
    test_flush();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
